// File: rtl/pit_pkg.sv
// rtl/pit_pkg.sv - shared width, zero constant and count type for the interval timer
package pit_pkg;
  localparam int PIT_CW = 16;
  typedef logic [PIT_CW-1:0] pit_cnt_t;
  localparam pit_cnt_t PIT_ZERO = '0;
endpackage

// File: rtl/pit_dncnt.sv
// rtl/pit_dncnt.sv - loadable down-counter with reload register and terminal-count decode
module pit_dncnt
  import pit_pkg::*;
#(
  parameter int CW = PIT_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] rld,
  output logic          tc
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rld;
  logic          w_zero;

  assign w_zero = (r_cnt == CW'(PIT_ZERO));

  // A load always wins; at zero the count reloads instead of borrowing to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rld <= '0;
    end else if (ld) begin
      r_rld <= ld_val;
      r_cnt <= ld_val;
    end else if (en) begin
      r_cnt <= w_zero ? r_rld : r_cnt - CW'(1);
    end
  end

  assign cnt = r_cnt;
  assign rld = r_rld;
  assign tc  = en & w_zero;

endmodule

// File: rtl/pit_timer.sv
// rtl/pit_timer.sv - prescaler/divider interval timer with one-cycle irq pulse
// Optional PIT_SNAPSHOT_EN adds snap-captured shadow registers on the readback path.
module pit_timer
  import pit_pkg::*;
#(
  parameter int CW = PIT_CW
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic [CW-1:0] din,
  input  logic          pre_we,
  input  logic          div_we,
  input  logic          snap,
  output logic [CW-1:0] pre_q,
  output logic [CW-1:0] div_q,
  output logic          irq,
  output logic          run
);

  logic [CW-1:0] w_pre_cnt;
  logic [CW-1:0] w_pre_rld;
  logic [CW-1:0] w_div_cnt;
  logic [CW-1:0] w_div_rld_unused;
  logic          w_pre_en;
  logic          w_pre_tc;
  logic          w_div_en;
  logic          w_div_tc;
  logic          r_irq;

  assign run      = (w_pre_rld != CW'(PIT_ZERO));
  assign w_pre_en = run & ~pre_we;
  // A divider write on a tick edge swallows that tick, so no irq can fire.
  assign w_div_en = w_pre_tc & ~div_we;

  pit_dncnt #(.CW(CW)) u_pre (
    .clk    (sys_clk),
    .rst_n  (resetl),
    .ld     (pre_we),
    .ld_val (din),
    .en     (w_pre_en),
    .cnt    (w_pre_cnt),
    .rld    (w_pre_rld),
    .tc     (w_pre_tc)
  );

  pit_dncnt #(.CW(CW)) u_div (
    .clk    (sys_clk),
    .rst_n  (resetl),
    .ld     (div_we),
    .ld_val (din),
    .en     (w_div_en),
    .cnt    (w_div_cnt),
    .rld    (w_div_rld_unused),
    .tc     (w_div_tc)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) r_irq <= 1'b0;
    else         r_irq <= w_div_tc;
  end

  assign irq = r_irq;

`ifdef PIT_SNAPSHOT_EN
  logic [CW-1:0] r_pre_snap;
  logic [CW-1:0] r_div_snap;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_pre_snap <= '0;
      r_div_snap <= '0;
    end else if (snap) begin
      r_pre_snap <= w_pre_cnt;
      r_div_snap <= w_div_cnt;
    end
  end

  assign pre_q = r_pre_snap;
  assign div_q = r_div_snap;
`else
  logic w_snap_unused;
  assign w_snap_unused = snap;
  assign pre_q = w_pre_cnt;
  assign div_q = w_div_cnt;
`endif

endmodule

// File: tb/tb_pit_timer.sv
// tb/tb_pit_timer.sv - vector table plus scoreboard bench for pit_timer
module tb_pit_timer;
  localparam int CW = 16;
`ifdef PIT_SNAPSHOT_EN
  localparam bit SNAP_BUILD = 1'b1;
`else
  localparam bit SNAP_BUILD = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          resetl  = 1'b0;
  logic [CW-1:0] din     = '0;
  logic          pre_we  = 1'b0;
  logic          div_we  = 1'b0;
  logic          snap    = 1'b0;
  logic [CW-1:0] pre_q;
  logic [CW-1:0] div_q;
  logic          irq;
  logic          run;

  always #5 sys_clk = ~sys_clk;

  pit_timer #(.CW(CW)) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .din     (din),
    .pre_we  (pre_we),
    .div_we  (div_we),
    .snap    (snap),
    .pre_q   (pre_q),
    .div_q   (div_q),
    .irq     (irq),
    .run     (run)
  );

  typedef struct {
    bit          pw;
    bit          dw;
    logic [15:0] d;
    bit          sn;
    logic [15:0] ep;
    logic [15:0] ed;
    bit          ei;
    bit          er;
  } vec_t;

  typedef struct {
    logic [15:0] pre;
    logic [15:0] dv;
    logic        irq;
    logic        run;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Expected live counters and shadow registers, tracked from the stimulus.
  logic [15:0] live_pre = '0, live_div = '0, sh_pre = '0, sh_div = '0;

  function automatic vec_t mk(bit pw, bit dw, logic [15:0] d, bit sn,
                              logic [15:0] ep, logic [15:0] ed, bit ei, bit er);
    vec_t v;
    v.pw = pw; v.dw = dw; v.d = d; v.sn = sn;
    v.ep = ep; v.ed = ed; v.ei = ei; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] ep, input logic [15:0] ed,
                       input logic ei, input logic er);
    n_tests++;
    if (pre_q !== ep || div_q !== ed || irq !== ei || run !== er) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got pre_q=%h div_q=%h irq=%b run=%b, want pre_q=%h div_q=%h irq=%b run=%b",
                 name, pre_q, div_q, irq, run, ep, ed, ei, er);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    exp_t e;
    pre_we = v.pw; div_we = v.dw; din = v.d; snap = v.sn;
    if (v.sn) begin
      sh_pre = live_pre;
      sh_div = live_div;
    end
    live_pre = v.ep;
    live_div = v.ed;
    e.pre  = SNAP_BUILD ? sh_pre : v.ep;
    e.dv   = SNAP_BUILD ? sh_div : v.ed;
    e.irq  = v.ei;
    e.run  = v.er;
    e.name = name;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    pre_we = 1'b0; div_we = 1'b0; snap = 1'b0; din = '0;
    e = sb.pop_front();
    check(e.name, e.pre, e.dv, e.irq, e.run);
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    pre_we = 1'b0; div_we = 1'b0; snap = 1'b0; din = '0;
    @(posedge sys_clk);
    #1;
    resetl = 1'b1;
    live_pre = '0; live_div = '0; sh_pre = '0; sh_div = '0;
  endtask

  initial begin
    logic [15:0] seq_pre[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [15:0] seq_div[12] = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};

    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_state", 16'h0, 16'h0, 1'b0, 1'b0);
    resetl = 1'b1;

    // Basic period: div=2 then pre=1, period (1+1)*(2+1)=6.
    tbl.push_back(mk(0, 1, 16'd2, 1, 16'd0, 16'd2, 0, 0));
    tbl.push_back(mk(1, 0, 16'd1, 1, 16'd1, 16'd2, 0, 1));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 0, 16'd0, 1, seq_pre[i], seq_div[i], (i == 5) || (i == 11), 1));
    // Divider write colliding with a terminal tick, then the new 12-cycle period.
    tbl.push_back(mk(0, 1, 16'd3, 1, 16'd0, 16'd3, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd1, 16'd2, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd0, 16'd2, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd1, 16'd1, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd0, 16'd1, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd1, 16'd0, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd0, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 16'd5, 1, 16'd1, 16'd5, 0, 1));
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(0, 0, 16'd0, 1, (i % 2 == 1) ? 16'd0 : 16'd1,
                       (i < 12) ? 16'(5 - i / 2) : 16'd5, i == 12, 1));
    tbl.push_back(mk(1, 1, 16'd2, 1, 16'd2, 16'd2, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 16'd1, 16'd2, 0, 1));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("tbl%0d", i));

    // Reset asserted mid-count clears everything at once and leaves nothing pending.
    do_reset();
    step(mk(1, 0, 16'd5, 1, 16'd5, 16'd0, 0, 1), "rst_load");
    step(mk(0, 0, 16'd0, 1, 16'd4, 16'd0, 0, 1), "rst_cnt1");
    step(mk(0, 0, 16'd0, 1, 16'd3, 16'd0, 0, 1), "rst_cnt2");
    #3 resetl = 1'b0;
    #1 check("rst_async", 16'h0, 16'h0, 1'b0, 1'b0);
    live_pre = '0; live_div = '0; sh_pre = '0; sh_div = '0;
    @(posedge sys_clk);
    #1 resetl = 1'b1;
    for (int i = 0; i < 100; i++)
      step(mk(0, 0, 16'd0, 1, 16'd0, 16'd0, 0, 0), $sformatf("rst_quiet%0d", i));

    // Prescaler 3, divider 0: irq every 4 cycles, then stop by writing 0.
    do_reset();
    step(mk(0, 1, 16'd0, 1, 16'd0, 16'd0, 0, 0), "stop_div");
    step(mk(1, 0, 16'd3, 1, 16'd3, 16'd0, 0, 1), "stop_pre");
    for (int k = 1; k <= 12; k++)
      step(mk(0, 0, 16'd0, 1, 16'((3 - k) & 3), 16'd0, (k % 4) == 0, 1), $sformatf("stop_run%0d", k));
    step(mk(1, 0, 16'd0, 1, 16'd0, 16'd0, 0, 0), "stop_write0");
    for (int i = 0; i < 20; i++)
      step(mk(0, 0, 16'd0, 1, 16'd0, 16'd0, 0, 0), $sformatf("stop_frozen%0d", i));

    // Snapshot capture at 7/2, hold while counting, then recapture.
    do_reset();
    step(mk(0, 1, 16'd2, 0, 16'd0, 16'd2, 0, 0), "snap_div");
    step(mk(1, 0, 16'd7, 0, 16'd7, 16'd2, 0, 1), "snap_pre");
    for (int k = 1; k <= 14; k++)
      step(mk(0, 0, 16'd0, (k == 1) || (k == 12), 16'((7 - k) & 7), (k < 8) ? 16'd2 : 16'd1, 0, 1),
           $sformatf("snap_seq%0d", k));

    // Maximum prescale: one full 65536-cycle period, no wrap below zero.
    do_reset();
    step(mk(1, 0, 16'hFFFF, 1, 16'hFFFF, 16'd0, 0, 1), "max_load");
    for (int k = 1; k <= 65537; k++)
      step(mk(0, 0, 16'd0, 1, 16'(65535 - k), 16'd0, k == 65536, 1), $sformatf("max%0d", k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pit_timer.md
Name: pit_timer

Overview:
- Programmable interval timer for the Tom interrupt path.
- Two cascaded loadable 16-bit down-counters: a prescaler and a divider.
- Emits a one-cycle interrupt pulse on divider terminal count.
- Counter values can be read back by the CPU bus interface.
- Counts in the opposite direction to the existing up/down counter cells; decrements, reloads and decodes terminal count.

Parameters:
- CW, 16, width of prescaler and divider counters and their reload registers.

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- resetl  in  1  asynchronous active-low reset.
- din  in  CW  CPU write data.
- pre_we  in  1  write strobe for the prescaler reload register.
- div_we  in  1  write strobe for the divider reload register.
- snap  in  1  snapshot strobe; used only with PIT_SNAPSHOT_EN, otherwise ignored.
- pre_q  out  CW  prescaler count readback.
- div_q  out  CW  divider count readback.
- irq  out  1  one-cycle timer interrupt pulse.
- run  out  1  timer running (pre_rld != 0).

Behaviour:
- Reset (async, resetl=0):
  - pre_rld, div_rld, pre_cnt and div_cnt all clear to 0.
  - irq=0, run=0, snapshot registers 0.
  - Reset mid-count aborts immediately; there is no pending irq after release.
- pre_we: pre_rld<=din and pre_cnt<=din in the same edge.
- div_we: div_rld<=din and div_cnt<=din in the same edge.
- run = (pre_rld != 0), combinational from the register. When run=0 both counters hold and irq=0.
- Prescaler, each edge with run=1 and no pre_we:
  - pre_cnt==0: pre_cnt<=pre_rld and assert internal tick.
  - Otherwise pre_cnt<=pre_cnt-1.
- Divider, on tick with no div_we:
  - div_cnt==0: div_cnt<=div_rld and irq<=1 for exactly one cycle.
  - Otherwise div_cnt<=div_cnt-1.
- irq is registered and is 0 on every cycle without a divider terminal event.
- Interrupt period is (pre_rld+1)*(div_rld+1) sys_clk cycles.
- div_rld=0 with run=1: irq fires on every prescaler tick.
- Simultaneous events:
  - A write to a counter wins over its decrement/reload in that edge.
  - A pre_we edge produces no tick.
  - A div_we in the same edge as a tick discards the tick (no irq).
  - pre_we and div_we together: both load.
- No borrow or wrap past 0. The count sequence is N..0 followed by reload; never 0 to FFFF.
- Readback: pre_q/div_q are the live counter values (registered state, no extra latency) unless the optional feature is compiled in.

Optional Feature:
- Macro: PIT_SNAPSHOT_EN.
- Defined:
  - snap=1 captures pre_cnt and div_cnt into shadow registers on that edge.
  - pre_q/div_q drive the shadows, giving a coherent 32-bit view for two-cycle CPU reads.
  - snap during a write edge captures the pre-write counter values.
  - Shadows reset to 0.
- Undefined: snap is unused and pre_q/div_q are live counters. There are no shadow flops.

Decomposition:
- Shared package pit_pkg:
  - PIT_CW=16.
  - Zero constant.
  - Typedef pit_cnt_t (logic [PIT_CW-1:0]).
- One natural sub-module, pit_dncnt: loadable down-counter with reload register.
  - Inputs: ld, ld_val, en.
  - Outputs: cnt, tc (terminal count = en & cnt==0).
  - Instanced twice; the prescaler tc drives the divider en.
- Top level holds run decode, irq flop and the optional snapshot.

Test Plan:
- Reset value check: assert resetl=0 mid-run with pre_rld=5 -> pre_q=div_q=0, irq=0, run=0 immediately; after release, no irq for 100 cycles.
- Basic period: write div=2, then pre=1 at edge N -> irq high for one cycle after edge N+6, then every 6 cycles. div_q sequence is 2,2,1,1,0,0,2.
- Prescaler stop: with pre=3 and div=0, irq every 4 cycles; write pre=0 -> run=0, counters frozen, no further irq.
- Write collision: pre=0x0001, div=0x0003; assert div_we=1 with din=0x0005 on the edge where div_cnt==0 and tick=1 -> no irq that cycle, div_q=0x0005, next irq 12 cycles later.
- Max values: pre=0xFFFF, div=0x0000 -> irq exactly every 65536 cycles; pre_q never reads above 0xFFFF and never wraps below 0.
- PIT_SNAPSHOT_EN build: snap when pre_q=0x0007, div_q=0x0002 -> outputs hold 0x0007/0x0002 while the internal counters continue; next snap updates them. Non-snapshot build: the same stimulus shows live values.
